// File: rtl/muu_ht_match.sv
// rtl/muu_ht_match.sv - hash-table bucket match stage (optional hit/miss counters: MUU_MATCH_STATS_EN)
module muu_ht_match #(
    parameter int KEY_WIDTH      = 128,
    parameter int META_WIDTH     = 96,
    parameter int HASHADDR_WIDTH = 64,
    parameter int USER_BITS      = 3,
    parameter int MEMDATA_WIDTH  = 512,
    parameter int SLOTS          = 3,
    parameter int PTR_WIDTH      = 31
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic [KEY_WIDTH+META_WIDTH+HASHADDR_WIDTH+USER_BITS-1:0]   key_data,
    input  logic                                                       key_valid,
    output logic                                                       key_ready,
    input  logic [MEMDATA_WIDTH-1:0]                                   rddata_data,
    input  logic                                                       rddata_valid,
    output logic                                                       rddata_ready,
    output logic [KEY_WIDTH+META_WIDTH+HASHADDR_WIDTH+USER_BITS-1:0]   output_data,
    output logic [7:0]                                                 output_status,
    output logic [MEMDATA_WIDTH-1:0]                                   output_bucket,
    output logic [PTR_WIDTH-1:0]                                       output_ptr,
    output logic                                                       output_valid,
    input  logic                                                       output_ready,
    output logic [31:0]                                                stat_hits,
    output logic [31:0]                                                stat_misses
);

    localparam int WORD_W  = KEY_WIDTH + META_WIDTH + HASHADDR_WIDTH + USER_BITS;
    localparam int SLOT_W  = KEY_WIDTH + PTR_WIDTH + 1;
    localparam int OPC_LSB = KEY_WIDTH + META_WIDTH - 8;

    // Opcodes that bypass the bucket lookup entirely
    localparam logic [3:0] HTOP_IGNORE     = 4'hE;
    localparam logic [3:0] HTOP_IGNOREPROP = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BKT1    = 3'd1,
        ST_BKT2    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WORD_W-1:0]        key_reg;
    logic [MEMDATA_WIDTH-1:0] bkt1, bkt2;
    logic [SLOTS-1:0]         match1, match2, free1, free2;
    logic [SLOTS-1:0]         rd_match, rd_free;
    logic                     is_ignore;

    logic                     hit, hit_bkt, free_found, free_bkt;
    logic [1:0]               hit_slot, free_slot;
    logic [PTR_WIDTH-1:0]     hit_ptr;
    logic [MEMDATA_WIDTH-1:0] sel_bucket;

    assign is_ignore = (key_data[OPC_LSB +: 4] == HTOP_IGNORE) ||
                       (key_data[OPC_LSB +: 4] == HTOP_IGNOREPROP);

    assign output_data = key_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake readies
    always_comb begin
        state_nxt    = state;
        key_ready    = 1'b0;
        rddata_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = is_ignore ? ST_OUTPUT : ST_BKT1;
            end
            ST_BKT1: begin
                rddata_ready = 1'b1;
                if (rddata_valid) state_nxt = ST_BKT2;
            end
            ST_BKT2: begin
                rddata_ready = 1'b1;
                if (rddata_valid) state_nxt = ST_RESOLVE;
            end
            ST_RESOLVE: state_nxt = ST_OUTPUT;
            ST_OUTPUT:  if (output_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Per-slot match (valid and key equal) and free (invalid) flags of the incoming bucket word
    always_comb begin
        rd_match = '0;
        rd_free  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            rd_free[i]  = ~rddata_data[i*SLOT_W + KEY_WIDTH + PTR_WIDTH];
            rd_match[i] = rddata_data[i*SLOT_W + KEY_WIDTH + PTR_WIDTH] &&
                          (rddata_data[i*SLOT_W +: KEY_WIDTH] == key_reg[KEY_WIDTH-1:0]);
        end
    end

    // Priority pick: bucket 2 scanned first so bucket 1 overrides; descending slots so lowest wins
    always_comb begin
        hit        = 1'b0;
        hit_bkt    = 1'b0;
        hit_slot   = 2'd0;
        hit_ptr    = '0;
        free_found = 1'b0;
        free_bkt   = 1'b0;
        free_slot  = 2'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (match2[i]) begin
                hit      = 1'b1;
                hit_bkt  = 1'b1;
                hit_slot = 2'(i);
                hit_ptr  = bkt2[i*SLOT_W + KEY_WIDTH +: PTR_WIDTH];
            end
            if (free2[i]) begin
                free_found = 1'b1;
                free_bkt   = 1'b1;
                free_slot  = 2'(i);
            end
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (match1[i]) begin
                hit      = 1'b1;
                hit_bkt  = 1'b0;
                hit_slot = 2'(i);
                hit_ptr  = bkt1[i*SLOT_W + KEY_WIDTH +: PTR_WIDTH];
            end
            if (free1[i]) begin
                free_found = 1'b1;
                free_bkt   = 1'b0;
                free_slot  = 2'(i);
            end
        end
        if (hit)                    sel_bucket = hit_bkt ? bkt2 : bkt1;
        else if (free_found)        sel_bucket = free_bkt ? bkt2 : bkt1;
        else                        sel_bucket = bkt1;
    end

    // Wide data captures; no reset needed since they are only observed behind valid
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && key_valid)     key_reg <= key_data;
        if (state == ST_BKT1 && rddata_valid)  bkt1    <= rddata_data;
        if (state == ST_BKT2 && rddata_valid)  bkt2    <= rddata_data;
        if (state == ST_RESOLVE)               output_bucket <= sel_bucket;
    end

    // Match vectors and result registers; reset drops any partially gathered lookup
    always_ff @(posedge clk) begin
        if (rst) begin
            match1        <= '0;
            match2        <= '0;
            free1         <= '0;
            free2         <= '0;
            output_valid  <= 1'b0;
            output_status <= 8'd0;
            output_ptr    <= '0;
        end else begin
            if (state == ST_IDLE && key_valid && is_ignore) begin
                output_valid  <= 1'b1;
                output_status <= 8'd0;
                output_ptr    <= '0;
            end
            if (state == ST_BKT1 && rddata_valid) begin
                match1 <= rd_match;
                free1  <= rd_free;
            end
            if (state == ST_BKT2 && rddata_valid) begin
                match2 <= rd_match;
                free2  <= rd_free;
            end
            if (state == ST_RESOLVE) begin
                output_valid  <= 1'b1;
                output_status <= {free_slot, free_bkt, free_found, hit_slot, hit_bkt, hit};
                output_ptr    <= hit ? hit_ptr : '0;
            end
            if (state == ST_OUTPUT && output_ready) output_valid <= 1'b0;
        end
    end

`ifdef MUU_MATCH_STATS_EN
    logic ign_reg;

    // Remember whether the in-flight key bypassed lookup so it is not counted as a miss
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && key_valid) ign_reg <= is_ignore;
    end

    // Saturating hit/miss counters, stepped on the output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
        end else if (state == ST_OUTPUT && output_ready) begin
            if (output_status[0]) begin
                if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
            end else if (!ign_reg) begin
                if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_muu_ht_match.sv
// tb/tb_muu_ht_match.sv - self-checking bench for muu_ht_match with a behavioural lookup model
module tb_muu_ht_match;

    localparam int KW  = 128;
    localparam int MTW = 96;
    localparam int HW  = 64;
    localparam int UW  = 3;
    localparam int MW  = 512;
    localparam int PW  = 31;
    localparam int SW  = KW + PW + 1;
    localparam int WW  = KW + MTW + HW + UW;
    localparam int OPC = KW + MTW - 8;

    localparam logic [3:0] HTOP_GET        = 4'h0;
    localparam logic [3:0] HTOP_SET        = 4'h1;
    localparam logic [3:0] HTOP_IGNORE     = 4'hE;
    localparam logic [3:0] HTOP_IGNOREPROP = 4'hF;

`ifdef MUU_MATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] key_data;
    logic          key_valid;
    logic          key_ready;
    logic [MW-1:0] rddata_data;
    logic          rddata_valid;
    logic          rddata_ready;
    logic [WW-1:0] output_data;
    logic [7:0]    output_status;
    logic [MW-1:0] output_bucket;
    logic [PW-1:0] output_ptr;
    logic          output_valid;
    logic          output_ready;
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hits = 32'd0;
    logic [31:0] exp_misses = 32'd0;

    muu_ht_match dut (
        .clk           (clk),
        .rst           (rst),
        .key_data      (key_data),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .rddata_data   (rddata_data),
        .rddata_valid  (rddata_valid),
        .rddata_ready  (rddata_ready),
        .output_data   (output_data),
        .output_status (output_status),
        .output_bucket (output_bucket),
        .output_ptr    (output_ptr),
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [PW-1:0] rnd_ptr();
        return PW'($urandom);
    endfunction

    function automatic logic [WW-1:0] mk_key(input logic [3:0] opc, input logic [KW-1:0] k);
        logic [319:0] t;
        logic [WW-1:0] w;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom};
        w = t[WW-1:0];
        w[KW-1:0] = k;
        w[OPC +: 4] = opc;
        return w;
    endfunction

    function automatic logic [MW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [MW-1:0] put_slot(input logic [MW-1:0] w, input int i, input logic v,
                                               input logic [PW-1:0] p, input logic [KW-1:0] k);
        logic [MW-1:0] r;
        r = w;
        r[i*SW +: SW] = {v, p, k};
        return r;
    endfunction

    function automatic bit is_ign(input logic [WW-1:0] kd);
        return (kd[OPC +: 4] == HTOP_IGNORE) || (kd[OPC +: 4] == HTOP_IGNOREPROP);
    endfunction

    // Reference: scan bucket 1 then bucket 2, slots in ascending order, first valid key hit wins
    function automatic void model(input logic [WW-1:0] kd, input logic [MW-1:0] b1, input logic [MW-1:0] b2,
                                  output logic [7:0] st, output logic [PW-1:0] p, output logic [MW-1:0] ob);
        logic [MW-1:0] bk [2];
        int hb, hs, fb, fs;
        logic v;
        bk[0] = b1;
        bk[1] = b2;
        hb = -1; hs = -1; fb = -1; fs = -1;
        st = 8'd0;
        p  = '0;
        ob = b1;
        if (!is_ign(kd)) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 3; s++) begin
                    v = bk[b][s*SW + SW - 1];
                    if (hb < 0 && v && bk[b][s*SW +: KW] == kd[KW-1:0]) begin
                        hb = b; hs = s;
                    end
                    if (fb < 0 && !v) begin
                        fb = b; fs = s;
                    end
                end
            end
            if (hb >= 0) begin
                st[0]   = 1'b1;
                st[1]   = (hb == 1);
                st[3:2] = 2'(hs);
                p       = bk[hb][hs*SW + KW +: PW];
                ob      = bk[hb];
            end else if (fb >= 0) begin
                ob = bk[fb];
            end
            if (fb >= 0) begin
                st[4]   = 1'b1;
                st[5]   = (fb == 1);
                st[7:6] = 2'(fs);
            end
        end
    endfunction

    task automatic note_handshake(input logic [WW-1:0] kd, input logic [7:0] st);
        if (st[0]) exp_hits = exp_hits + 32'd1;
        else if (!is_ign(kd)) exp_misses = exp_misses + 32'd1;
    endtask

    task automatic send_key(input logic [WW-1:0] kd, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        key_data = kd;
        key_valid = 1'b1;
        while (!key_ready && n < 64) begin tick(); n++; end
        if (!key_ready) to = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic send_word(input logic [MW-1:0] w, input int gap, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        rddata_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        rddata_data = w;
        rddata_valid = 1'b1;
        while (!rddata_ready && n < 64) begin tick(); n++; end
        if (!rddata_ready) to = 1'b1;
        tick();
        rddata_valid = 1'b0;
    endtask

    task automatic wait_out(output bit to);
        int n;
        n = 0;
        while (!output_valid && n < 64) begin tick(); n++; end
        to = !output_valid;
    endtask

    task automatic run_txn(input logic [WW-1:0] kd, input logic [MW-1:0] b1, input logic [MW-1:0] b2,
                           input int gap, output logic [7:0] st, output logic [PW-1:0] p,
                           output logic [MW-1:0] ob, output logic [WW-1:0] od, output bit to);
        bit t;
        to = 1'b0;
        send_key(kd, t); to |= t;
        if (!is_ign(kd)) begin
            send_word(b1, gap, t); to |= t;
            send_word(b2, gap, t); to |= t;
        end
        wait_out(t); to |= t;
        st = output_status;
        p  = output_ptr;
        ob = output_bucket;
        od = output_data;
        output_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", output_valid); end
        checks++; if (output_status !== 8'd0) begin errors++; $display("FAIL reset_status: got %h exp 00", output_status); end
        checks++; if (output_ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %h exp 0", output_ptr); end
        checks++; if (key_ready !== 1'b1 || rddata_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: key_ready=%b rddata_ready=%b exp 1/0", key_ready, rddata_ready); end
        checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", stat_hits, stat_misses); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hit_basic();
        logic [WW-1:0] kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        bit to;
        kd = mk_key(HTOP_GET, 128'h1234);
        b1 = rnd_word();
        b1 = put_slot(b1, 0, 1'b0, rnd_ptr(), rnd128());
        b1 = put_slot(b1, 1, 1'b1, rnd_ptr(), rnd128());
        b1 = put_slot(b1, 2, 1'b1, 31'h55, 128'h1234);
        b2 = rnd_word();
        for (int s = 0; s < 3; s++) b2 = put_slot(b2, s, 1'b0, rnd_ptr(), rnd128());
        model(kd, b1, b2, est, ep, eob);
        run_txn(kd, b1, b2, 1, st, p, ob, od, to);
        note_handshake(kd, est);
        checks++; if (to) begin errors++; $display("FAIL hit_basic_timeout: got timeout exp handshake"); end
        checks++; if (st !== 8'h19) begin errors++; $display("FAIL hit_basic_status: got %h exp 19", st); end
        checks++; if (p !== 31'h55) begin errors++; $display("FAIL hit_basic_ptr: got %h exp 55", p); end
        checks++; if (ob !== b1) begin errors++; $display("FAIL hit_basic_bucket: got %h exp %h", ob, b1); end
        checks++; if (od !== kd) begin errors++; $display("FAIL hit_basic_data: got %h exp %h", od, kd); end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL hit_basic_clear: got %b exp 0", output_valid); end
    endtask

    task automatic test_dual_hit();
        logic [WW-1:0] kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        logic [KW-1:0] k;
        bit to;
        k  = rnd128();
        kd = mk_key(HTOP_SET, k);
        b1 = rnd_word();
        b1 = put_slot(b1, 0, 1'b1, rnd_ptr(), rnd128());
        b1 = put_slot(b1, 1, 1'b1, 31'h1ABC, k);
        b1 = put_slot(b1, 2, 1'b0, rnd_ptr(), rnd128());
        b2 = rnd_word();
        b2 = put_slot(b2, 0, 1'b1, 31'h2DEF, k);
        b2 = put_slot(b2, 1, 1'b0, rnd_ptr(), rnd128());
        b2 = put_slot(b2, 2, 1'b1, rnd_ptr(), rnd128());
        model(kd, b1, b2, est, ep, eob);
        run_txn(kd, b1, b2, 0, st, p, ob, od, to);
        note_handshake(kd, est);
        checks++; if (to) begin errors++; $display("FAIL dual_hit_timeout: got timeout exp handshake"); end
        checks++; if (st[3:1] !== 3'b010 || st !== est) begin errors++; $display("FAIL dual_hit_status: got %h exp %h", st, est); end
        checks++; if (p !== 31'h1ABC) begin errors++; $display("FAIL dual_hit_ptr: got %h exp 1abc", p); end
        checks++; if (ob !== b1) begin errors++; $display("FAIL dual_hit_bucket: got %h exp %h", ob, b1); end
    endtask

    task automatic test_invalid_match();
        logic [WW-1:0] kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        logic [KW-1:0] k;
        bit to;
        k  = rnd128();
        kd = mk_key(HTOP_GET, k);
        b1 = rnd_word();
        b1 = put_slot(b1, 0, 1'b0, 31'h11, k);
        b1 = put_slot(b1, 1, 1'b1, rnd_ptr(), rnd128());
        b1 = put_slot(b1, 2, 1'b1, 31'h33, k);
        b2 = rnd_word();
        for (int s = 0; s < 3; s++) b2 = put_slot(b2, s, 1'b1, rnd_ptr(), rnd128());
        model(kd, b1, b2, est, ep, eob);
        run_txn(kd, b1, b2, 2, st, p, ob, od, to);
        note_handshake(kd, est);
        checks++; if (to) begin errors++; $display("FAIL invalid_match_timeout: got timeout exp handshake"); end
        checks++; if (st !== 8'h19 || st !== est) begin errors++; $display("FAIL invalid_match_status: got %h exp 19", st); end
        checks++; if (p !== 31'h33) begin errors++; $display("FAIL invalid_match_ptr: got %h exp 33", p); end
    endtask

    task automatic test_miss_free();
        logic [WW-1:0] kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        bit to;
        kd = mk_key(HTOP_GET, rnd128());
        b1 = rnd_word();
        for (int s = 0; s < 3; s++) b1 = put_slot(b1, s, 1'b1, rnd_ptr(), rnd128());
        b2 = rnd_word();
        b2 = put_slot(b2, 0, 1'b1, rnd_ptr(), rnd128());
        b2 = put_slot(b2, 1, 1'b0, rnd_ptr(), rnd128());
        b2 = put_slot(b2, 2, 1'b1, rnd_ptr(), rnd128());
        model(kd, b1, b2, est, ep, eob);
        run_txn(kd, b1, b2, 1, st, p, ob, od, to);
        note_handshake(kd, est);
        checks++; if (to) begin errors++; $display("FAIL miss_timeout: got timeout exp handshake"); end
        checks++; if (st !== 8'h70) begin errors++; $display("FAIL miss_status: got %h exp 70", st); end
        checks++; if (p !== '0) begin errors++; $display("FAIL miss_ptr: got %h exp 0", p); end
        checks++; if (ob !== b2) begin errors++; $display("FAIL miss_bucket: got %h exp %h", ob, b2); end
        checks++; if (stat_misses !== (STATS ? exp_misses : 32'd0)) begin errors++; $display("FAIL miss_stat: got %0d exp %0d", stat_misses, STATS ? exp_misses : 32'd0); end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] kd;
        logic [MW-1:0] b1, b2, eob;
        logic [7:0] est;
        logic [PW-1:0] ep;
        bit to, t;
        kd = mk_key(HTOP_GET, rnd128());
        b1 = rnd_word();
        b2 = rnd_word();
        b2 = put_slot(b2, 2, 1'b1, rnd_ptr(), kd[KW-1:0]);
        model(kd, b1, b2, est, ep, eob);
        to = 1'b0;
        send_key(kd, t); to |= t;
        checks++; if (rddata_ready !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL b2b_bkt1_ready: rddata_ready=%b key_ready=%b exp 1/0", rddata_ready, key_ready); end
        send_word(b1, 0, t); to |= t;
        send_word(b2, 0, t); to |= t;
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got timeout exp consecutive accept"); end
        checks++; if (output_valid !== 1'b0 || rddata_ready !== 1'b0) begin errors++; $display("FAIL b2b_resolve: valid=%b rddata_ready=%b exp 0/0", output_valid, rddata_ready); end
        rddata_data = rnd_word();
        rddata_valid = 1'b1;
        tick();
        checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL b2b_latency: got valid=%b exp 1", output_valid); end
        checks++; if (output_status !== est || output_ptr !== ep || output_bucket !== eob) begin errors++; $display("FAIL b2b_result: got %h/%h exp %h/%h", output_status, output_ptr, est, ep); end
        checks++; if (rddata_ready !== 1'b0) begin errors++; $display("FAIL b2b_output_ready: got %b exp 0", rddata_ready); end
        tick();
        note_handshake(kd, est);
        rddata_valid = 1'b0;
        checks++; if (output_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL b2b_done: valid=%b key_ready=%b exp 0/1", output_valid, key_ready); end
    endtask

    task automatic test_ignore_pending();
        logic [WW-1:0] ki, kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        logic [31:0] h0, m0;
        bit to, t, saw_ready;
        h0 = stat_hits;
        m0 = stat_misses;
        kd = mk_key(HTOP_GET, rnd128());
        b1 = rnd_word();
        b1 = put_slot(b1, 0, 1'b1, 31'h4242, kd[KW-1:0]);
        b2 = rnd_word();
        model(kd, b1, b2, est, ep, eob);
        ki = mk_key(($urandom_range(0, 1) != 0) ? HTOP_IGNORE : HTOP_IGNOREPROP, kd[KW-1:0]);
        rddata_data  = b1;
        rddata_valid = 1'b1;
        saw_ready = 1'b0;
        send_key(ki, t);
        to = t;
        saw_ready |= rddata_ready;
        checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL ignore_latency: got valid=%b exp 1", output_valid); end
        checks++; if (output_status !== 8'd0 || output_ptr !== '0) begin errors++; $display("FAIL ignore_result: got %h/%h exp 00/0", output_status, output_ptr); end
        checks++; if (output_data !== ki) begin errors++; $display("FAIL ignore_data: got %h exp %h", output_data, ki); end
        tick();
        saw_ready |= rddata_ready;
        checks++; if (saw_ready || to) begin errors++; $display("FAIL ignore_rddata_ready: asserted=%b timeout=%b exp 0/0", saw_ready, to); end
        checks++; if (stat_hits !== h0 || stat_misses !== m0) begin errors++; $display("FAIL ignore_stats: got %0d/%0d exp %0d/%0d", stat_hits, stat_misses, h0, m0); end
        run_txn(kd, b1, b2, 0, st, p, ob, od, to);
        note_handshake(kd, est);
        checks++; if (to) begin errors++; $display("FAIL pending_timeout: got timeout exp handshake"); end
        checks++; if (st !== est || p !== 31'h4242 || ob !== b1) begin errors++; $display("FAIL pending_result: got %h/%h exp %h/4242", st, p, est); end
    endtask

    task automatic test_stall();
        logic [WW-1:0] kd1, kd2, od;
        logic [MW-1:0] b1, b2, c1, c2, ob, eob, eob2;
        logic [7:0] st, est, est2;
        logic [PW-1:0] p, ep, ep2;
        bit to, t;
        int bad;
        kd1 = mk_key(HTOP_SET, rnd128());
        b1 = rnd_word();
        b2 = rnd_word();
        b2 = put_slot(b2, 1, 1'b1, rnd_ptr(), kd1[KW-1:0]);
        model(kd1, b1, b2, est, ep, eob);
        kd2 = mk_key(HTOP_GET, rnd128());
        c1 = rnd_word();
        c2 = rnd_word();
        c1 = put_slot(c1, 2, 1'b1, rnd_ptr(), kd2[KW-1:0]);
        model(kd2, c1, c2, est2, ep2, eob2);
        output_ready = 1'b0;
        to = 1'b0;
        send_key(kd1, t); to |= t;
        send_word(b1, 0, t); to |= t;
        send_word(b2, 0, t); to |= t;
        wait_out(t); to |= t;
        checks++; if (to) begin errors++; $display("FAIL stall_timeout: got timeout exp valid"); end
        key_data  = kd2;
        key_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (output_valid !== 1'b1 || output_status !== est || output_ptr !== ep ||
                output_bucket !== eob || output_data !== kd1 || key_ready !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles exp 0 (status %h exp %h)", bad, output_status, est); end
        output_ready = 1'b1;
        tick();
        note_handshake(kd1, est);
        checks++; if (key_ready !== 1'b1 || output_valid !== 1'b0) begin errors++; $display("FAIL stall_release: key_ready=%b valid=%b exp 1/0", key_ready, output_valid); end
        run_txn(kd2, c1, c2, 0, st, p, ob, od, to);
        note_handshake(kd2, est2);
        checks++; if (to || st !== est2 || p !== ep2 || od !== kd2) begin errors++; $display("FAIL stall_next: got %h/%h exp %h/%h", st, p, est2, ep2); end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        bit to, t;
        kd = mk_key(HTOP_GET, rnd128());
        b1 = rnd_word();
        b1 = put_slot(b1, 0, 1'b1, rnd_ptr(), kd[KW-1:0]);
        send_key(kd, t);
        send_word(b1, 0, t);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hits = 32'd0;
        exp_misses = 32'd0;
        checks++; if (key_ready !== 1'b1 || rddata_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_state: key_ready=%b rddata_ready=%b exp 1/0", key_ready, rddata_ready); end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b exp 0", output_valid); end
        checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin errors++; $display("FAIL rst_mid_stats: got %0d/%0d exp 0/0", stat_hits, stat_misses); end
        kd = mk_key(HTOP_GET, rnd128());
        b1 = rnd_word();
        b2 = rnd_word();
        b2 = put_slot(b2, 0, 1'b0, rnd_ptr(), rnd128());
        model(kd, b1, b2, est, ep, eob);
        run_txn(kd, b1, b2, 1, st, p, ob, od, to);
        note_handshake(kd, est);
        checks++; if (to || st !== est || p !== ep || ob !== eob) begin errors++; $display("FAIL rst_mid_next: got %h/%h exp %h/%h", st, p, est, ep); end
    endtask

    task automatic test_random();
        logic [WW-1:0] kd, od;
        logic [MW-1:0] b1, b2, ob, eob;
        logic [7:0] st, est;
        logic [PW-1:0] p, ep;
        logic [KW-1:0] k;
        logic [3:0] opc;
        bit to;
        int r;
        for (int it = 0; it < 60; it++) begin
            k = rnd128();
            r = $urandom_range(0, 9);
            opc = (r == 0) ? HTOP_IGNORE : (r == 1) ? HTOP_IGNOREPROP : (r < 6) ? HTOP_GET : HTOP_SET;
            kd = mk_key(opc, k);
            b1 = rnd_word();
            b2 = rnd_word();
            for (int s = 0; s < 3; s++) begin
                b1 = put_slot(b1, s, $urandom_range(0, 3) != 0, rnd_ptr(), ($urandom_range(0, 3) == 0) ? k : rnd128());
                b2 = put_slot(b2, s, $urandom_range(0, 3) != 0, rnd_ptr(), ($urandom_range(0, 3) == 0) ? k : rnd128());
            end
            model(kd, b1, b2, est, ep, eob);
            run_txn(kd, b1, b2, $urandom_range(0, 2), st, p, ob, od, to);
            note_handshake(kd, est);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout[%0d]: got timeout exp handshake", it); end
            checks++; if (st !== est) begin errors++; $display("FAIL rand_status[%0d]: got %h exp %h", it, st, est); end
            checks++; if (p !== ep) begin errors++; $display("FAIL rand_ptr[%0d]: got %h exp %h", it, p, ep); end
            checks++; if (od !== kd) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", it, od, kd); end
            if (!is_ign(kd)) begin
                checks++; if (ob !== eob) begin errors++; $display("FAIL rand_bucket[%0d]: got %h exp %h", it, ob, eob); end
            end
        end
        checks++; if (stat_hits !== (STATS ? exp_hits : 32'd0)) begin errors++; $display("FAIL rand_stat_hits: got %0d exp %0d", stat_hits, STATS ? exp_hits : 32'd0); end
        checks++; if (stat_misses !== (STATS ? exp_misses : 32'd0)) begin errors++; $display("FAIL rand_stat_misses: got %0d exp %0d", stat_misses, STATS ? exp_misses : 32'd0); end
    endtask

    initial begin
        rst          = 1'b1;
        key_data     = '0;
        key_valid    = 1'b0;
        rddata_data  = '0;
        rddata_valid = 1'b0;
        output_ready = 1'b1;
        test_reset();
        test_hit_basic();
        test_dual_hit();
        test_invalid_match();
        test_miss_free();
        test_back_to_back();
        test_ignore_pending();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
